// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - block memory READ/WRITE/BUSYWAIT handshake bundle
interface mem_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              READ;
   logic              WRITE;
   logic [ADDR_W-1:0] ADDRESS;
   logic [DATA_W-1:0] WRITEDATA;
   logic [DATA_W-1:0] READDATA;
   logic              BUSYWAIT;

   // side that issues accesses (a cache, or the arbiter toward memory)
   modport master (
      output READ, WRITE, ADDRESS, WRITEDATA,
      input  READDATA, BUSYWAIT
   );

   // side that services accesses (memory, or the arbiter toward a cache)
   modport slave (
      input  READ, WRITE, ADDRESS, WRITEDATA,
      output READDATA, BUSYWAIT
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter onto one block memory; MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed D priority
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic          CLK,
   input  logic          RESET_N,
   mem_arbiter_if.slave  I,
   mem_arbiter_if.slave  D,
   mem_arbiter_if.master MEM,
   output logic [1:0]    GRANT,
   output logic          ERR
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t            state;
   logic [1:0]        wait_cnt;
   logic              last_d;      // 1 when the last completed access belonged to D
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] i_rdata;
   logic [DATA_W-1:0] d_rdata;
   logic [1:0]        i_ill_cnt;
   logic [1:0]        d_ill_cnt;

   logic i_req, d_req, i_ill, d_ill, pick_i, pick_d;

   // a legal request has exactly one strobe; both strobes is an illegal request
   assign i_req = I.READ ^ I.WRITE;
   assign d_req = D.READ ^ D.WRITE;
   assign i_ill = I.READ & I.WRITE;
   assign d_ill = D.READ & D.WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // on a tie, D wins only if I was served last
   assign pick_d = d_req & (~i_req | ~last_d);
`else
   // D always wins a tie; the pointer is kept but plays no part in the choice
   assign pick_d = d_req;
   logic unused_last_d;
   assign unused_last_d = last_d;
`endif
   assign pick_i = i_req & ~pick_d;

   assign MEM.READ      = mem_rd;
   assign MEM.WRITE     = mem_wr;
   assign MEM.ADDRESS   = mem_addr;
   assign MEM.WRITEDATA = mem_wdata;
   assign I.READDATA    = i_rdata;
   assign D.READDATA    = d_rdata;

   // a requester stalls until the single RESPOND cycle of its own access
   assign I.BUSYWAIT = (I.READ | I.WRITE) & ~((state == RESPOND) & GRANT[0]);
   assign D.BUSYWAIT = (D.READ | D.WRITE) & ~((state == RESPOND) & GRANT[1]);

   // ERR fires on the first cycle of an illegal request and every 4th cycle it is held
   assign ERR = RESET_N & ((i_ill & (i_ill_cnt == 2'd0)) | (d_ill & (d_ill_cnt == 2'd0)));

   // per-port phase counters for the repeating illegal-request pulse
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         i_ill_cnt <= 2'd0;
         d_ill_cnt <= 2'd0;
      end else begin
         i_ill_cnt <= i_ill ? i_ill_cnt + 2'd1 : 2'd0;
         d_ill_cnt <= d_ill ? d_ill_cnt + 2'd1 : 2'd0;
      end
   end

   // access sequencer: latch winner, run the memory handshake, return data
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         GRANT     <= 2'b00;
         wait_cnt  <= 2'd0;
         last_d    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= 2'd0;
               if (pick_i | pick_d) begin
                  GRANT     <= {pick_d, pick_i};
                  mem_addr  <= pick_d ? D.ADDRESS   : I.ADDRESS;
                  mem_wdata <= pick_d ? D.WRITEDATA : I.WRITEDATA;
                  mem_rd    <= pick_d ? D.READ      : I.READ;
                  mem_wr    <= pick_d ? D.WRITE     : I.WRITE;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt != 2'd3)
                  wait_cnt <= wait_cnt + 2'd1;
               // skip the first ACCESS cycle: memory busywait may still be rising then
               if ((wait_cnt != 2'd0) && !MEM.BUSYWAIT) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (mem_rd) begin
                     if (GRANT[0]) i_rdata <= MEM.READDATA;
                     if (GRANT[1]) d_rdata <= MEM.READDATA;
                  end
                  state <= RESPOND;
               end
            end
            RESPOND: begin
               last_d <= GRANT[1];
               GRANT  <= 2'b00;
               state  <= IDLE;
            end
            default: begin
               GRANT  <= 2'b00;
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [1:0]        GRANT;
   logic              ERR;
   int                n_checks = 0;
   int                n_fails = 0;
   int                mem_cnt = 0;
   int                mem_wait = 1;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] wr_blk;
   logic [1:0]        exp_g;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .I       (i_bus),
      .D       (d_bus),
      .MEM     (mem_bus),
      .GRANT   (GRANT),
      .ERR     (ERR)
   );

   always #5 CLK = ~CLK;

   // memory model: busywait rises with the strobe and stays up for mem_wait cycles
   always @(posedge CLK) begin
      if (mem_bus.READ | mem_bus.WRITE) mem_cnt <= mem_cnt + 1;
      else                              mem_cnt <= 0;
   end
   assign mem_bus.BUSYWAIT = (mem_bus.READ | mem_bus.WRITE) && (mem_cnt < mem_wait);
   assign mem_bus.READDATA = mem_rdata;

   task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before timeout");
      $fatal(1);
   end

   initial begin
      i_bus.READ = 0; i_bus.WRITE = 0; i_bus.ADDRESS = '0; i_bus.WRITEDATA = '0;
      d_bus.READ = 0; d_bus.WRITE = 0; d_bus.ADDRESS = '0; d_bus.WRITEDATA = '0;
      RESET_N = 0;
      repeat (2) tick();
      check_value("rst_grant", GRANT, 2'b00);
      check_value("rst_mem_read", mem_bus.READ, 1'b0);
      check_value("rst_mem_write", mem_bus.WRITE, 1'b0);
      check_value("rst_mem_addr", mem_bus.ADDRESS, 28'h0);
      check_value("rst_err", ERR, 1'b0);
      check_value("rst_i_rdata", i_bus.READDATA, 128'h0);
      check_value("rst_d_rdata", d_bus.READDATA, 128'h0);
      RESET_N = 1;
      tick();

      // D read, single-cycle memory
      mem_wait = 1; mem_rdata = {16{8'hA5}};
      d_bus.READ = 1; d_bus.ADDRESS = 28'h0000010;
      #1;
      check_value("t1_c0_dbusy", d_bus.BUSYWAIT, 1'b1);
      tick();
      check_value("t1_c1_mread", mem_bus.READ, 1'b1);
      check_value("t1_c1_grant", GRANT, 2'b10);
      check_value("t1_c1_addr", mem_bus.ADDRESS, 28'h0000010);
      check_value("t1_c1_dbusy", d_bus.BUSYWAIT, 1'b1);
      tick();
      check_value("t1_c2_mread", mem_bus.READ, 1'b1);
      check_value("t1_c2_grant", GRANT, 2'b10);
      check_value("t1_c2_dbusy", d_bus.BUSYWAIT, 1'b1);
      tick();
      check_value("t1_c3_mread", mem_bus.READ, 1'b0);
      check_value("t1_c3_grant", GRANT, 2'b10);
      check_value("t1_c3_dbusy", d_bus.BUSYWAIT, 1'b0);
      check_value("t1_c3_rdata", d_bus.READDATA, {16{8'hA5}});
      d_bus.READ = 0;
      tick();
      check_value("t1_c4_grant", GRANT, 2'b00);

      // I write
      wr_blk = {2{64'h0123456789ABCDEF}};
      i_bus.WRITE = 1; i_bus.ADDRESS = 28'h0000004; i_bus.WRITEDATA = wr_blk;
      tick();
      check_value("t2_c1_mwrite", mem_bus.WRITE, 1'b1);
      check_value("t2_c1_mread", mem_bus.READ, 1'b0);
      check_value("t2_c1_addr", mem_bus.ADDRESS, 28'h0000004);
      check_value("t2_c1_wdata", mem_bus.WRITEDATA, wr_blk);
      check_value("t2_c1_grant", GRANT, 2'b01);
      tick();
      check_value("t2_c2_mwrite", mem_bus.WRITE, 1'b1);
      check_value("t2_c2_wdata", mem_bus.WRITEDATA, wr_blk);
      check_value("t2_c2_ibusy", i_bus.BUSYWAIT, 1'b1);
      tick();
      check_value("t2_c3_mwrite", mem_bus.WRITE, 1'b0);
      check_value("t2_c3_ibusy", i_bus.BUSYWAIT, 1'b0);
      check_value("t2_c3_irdata", i_bus.READDATA, 128'h0);
      i_bus.WRITE = 0;
      tick();
      check_value("t2_c4_grant", GRANT, 2'b00);

      // simultaneous I and D reads held across completions
      mem_rdata = {16{8'h5A}};
      i_bus.READ = 1; i_bus.ADDRESS = 28'h0000100;
      d_bus.READ = 1; d_bus.ADDRESS = 28'h0000200;
      tick();
      for (int g = 0; g < 4; g++) begin
         exp_g = (RR && (g % 2 == 1)) ? 2'b01 : 2'b10;
         check_value($sformatf("t3_g%0d_grant", g), GRANT, exp_g);
         check_value($sformatf("t3_g%0d_addr", g), mem_bus.ADDRESS,
                     exp_g[1] ? 28'h0000200 : 28'h0000100);
         if (g < 3) begin
            repeat (3) tick();
            check_value($sformatf("t3_g%0d_gap", g), GRANT, 2'b00);
            tick();
         end else begin
            repeat (2) tick();
            i_bus.READ = 0; d_bus.READ = 0;
            tick();
         end
      end
      check_value("t3_end_grant", GRANT, 2'b00);
      check_value("t3_end_drdata", d_bus.READDATA, {16{8'h5A}});
      check_value("t3_end_irdata", i_bus.READDATA, RR ? {16{8'h5A}} : 128'h0);

      // stretched memory busywait
      mem_wait = 5; mem_rdata = {16{8'h3C}};
      d_bus.READ = 1; d_bus.ADDRESS = 28'h0000020;
      tick();
      for (int c = 1; c <= 6; c++) begin
         check_value($sformatf("t4_c%0d_mread", c), mem_bus.READ, 1'b1);
         check_value($sformatf("t4_c%0d_addr", c), mem_bus.ADDRESS, 28'h0000020);
         check_value($sformatf("t4_c%0d_dbusy", c), d_bus.BUSYWAIT, 1'b1);
         tick();
      end
      check_value("t4_c7_mread", mem_bus.READ, 1'b0);
      check_value("t4_c7_dbusy", d_bus.BUSYWAIT, 1'b0);
      check_value("t4_c7_rdata", d_bus.READDATA, {16{8'h3C}});
      d_bus.READ = 0;
      mem_wait = 1;
      tick();

      // illegal D request held 8 cycles with a concurrent legal I read
      mem_rdata = {16{8'hC3}};
      d_bus.READ = 1; d_bus.WRITE = 1;
      i_bus.READ = 1; i_bus.ADDRESS = 28'h0000008;
      #1;
      for (int c = 0; c < 8; c++) begin
         check_value($sformatf("t5_c%0d_err", c), ERR, (c == 0 || c == 4) ? 1'b1 : 1'b0);
         check_value($sformatf("t5_c%0d_grant", c), GRANT,
                     (c >= 1 && c <= 3) ? 2'b01 : 2'b00);
         check_value($sformatf("t5_c%0d_dbusy", c), d_bus.BUSYWAIT, 1'b1);
         if (c == 3) begin
            check_value("t5_c3_irdata", i_bus.READDATA, {16{8'hC3}});
            check_value("t5_c3_ibusy", i_bus.BUSYWAIT, 1'b0);
            i_bus.READ = 0;
         end
         tick();
      end
      d_bus.READ = 0; d_bus.WRITE = 0;
      #1;
      check_value("t5_end_err", ERR, 1'b0);
      check_value("t5_end_drdata", d_bus.READDATA, {16{8'h3C}});
      tick();

      // reset during the second ACCESS cycle
      mem_rdata = {16{8'h77}};
      d_bus.READ = 1; d_bus.ADDRESS = 28'h0000030;
      tick();
      check_value("t6_c1_mread", mem_bus.READ, 1'b1);
      tick();
      RESET_N = 0;
      #1;
      check_value("t6_rst_mread", mem_bus.READ, 1'b0);
      check_value("t6_rst_grant", GRANT, 2'b00);
      check_value("t6_rst_err", ERR, 1'b0);
      check_value("t6_rst_addr", mem_bus.ADDRESS, 28'h0);
      check_value("t6_rst_drdata", d_bus.READDATA, 128'h0);
      d_bus.READ = 0;
      tick();
      RESET_N = 1;
      tick();
      check_value("t6_idle_grant", GRANT, 2'b00);
      i_bus.READ = 1; i_bus.ADDRESS = 28'h0000040;
      tick();
      check_value("t6_c1_grant", GRANT, 2'b01);
      check_value("t6_c1_addr", mem_bus.ADDRESS, 28'h0000040);
      repeat (2) tick();
      check_value("t6_c3_irdata", i_bus.READDATA, {16{8'h77}});
      check_value("t6_c3_ibusy", i_bus.BUSYWAIT, 1'b0);
      i_bus.READ = 0;
      tick();
      check_value("t6_c4_grant", GRANT, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer sharing the single 128-bit block data memory between the instruction cache (port I) and the data cache (port D).
- Latches one requester's access, drives the memory's READ/WRITE/BUSYWAIT handshake and returns read data.
- Presents each cache with the same READ/WRITE/BUSYWAIT interface the memory exposes.

Parameters:
- ADDR_W, 28, block address width (16-byte blocks).
- DATA_W, 128, block data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- I_READ  in  1  instruction-cache block read request.
- I_WRITE  in  1  instruction-cache block write request.
- I_ADDRESS  in  ADDR_W  I block address.
- I_WRITEDATA  in  DATA_W  I write block.
- I_READDATA  out  DATA_W  I read block, registered.
- I_BUSYWAIT  out  1  I stall.
- D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA, D_READDATA, D_BUSYWAIT: same directions, widths and meanings for the data cache.
- MEM_READ  out  1  memory read strobe, registered.
- MEM_WRITE  out  1  memory write strobe, registered.
- MEM_ADDRESS  out  ADDR_W  latched address.
- MEM_WRITEDATA  out  DATA_W  latched write block.
- MEM_READDATA  in  DATA_W  memory read block.
- MEM_BUSYWAIT  in  1  memory stall; high while an access is pending.
- GRANT  out  2  one-hot owner: [0]=I, [1]=D; 00 when idle.
- ERR  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE; GRANT=00; MEM_READ=MEM_WRITE=0; MEM_ADDRESS, MEM_WRITEDATA, I_READDATA, D_READDATA=0; ERR=0; last-grant pointer=I.
- Reset mid-access: the memory strobes drop immediately and the access is abandoned with no response.
- Request: port p requests when exactly one of p_READ/p_WRITE is high.
- Illegal request: READ and WRITE both high. It is never granted, pulses ERR for 1 cycle (re-pulses every 4th cycle while held), and that port's BUSYWAIT stays high.
- p_BUSYWAIT (combinational): (p_READ|p_WRITE) & !(state==RESPOND & GRANT==p).
- FSM, IDLE: if any legal request, pick a winner:
  - Record it in GRANT.
  - Latch the winner's ADDRESS/WRITEDATA into the MEM_ registers.
  - Set MEM_READ or MEM_WRITE.
  - Go to ACCESS.
- FSM, ACCESS: hold strobes and latched values; requester inputs are ignored.
  - wait_cnt increments each cycle.
  - When wait_cnt>=1 and MEM_BUSYWAIT==0 is sampled: clear strobes; on a read, capture MEM_READDATA into p_READDATA; go to RESPOND.
  - Minimum 2 cycles, so the memory's combinational busywait rise is never mistaken for completion.
- FSM, RESPOND (1 cycle): p_BUSYWAIT=0; p_READDATA valid; update last-grant pointer; go to IDLE, GRANT=00.
- Requester contract: drop READ/WRITE during RESPOND. A request still held in IDLE is a new access.
- Loser: keeps BUSYWAIT high throughout. Its READDATA register is unchanged.
- Latency:
  - Single-cycle memory: request seen in IDLE at edge 0; RESPOND in cycle 3; next grant decided in IDLE at cycle 4.
  - Each extra memory wait cycle adds 1.
- Write: p_READDATA is untouched.
- Simultaneous I and D requests in IDLE: priority per the optional feature.
- A request arriving during ACCESS/RESPOND waits for IDLE.
- wait_cnt is 2 bits, saturating at 3.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the port not granted last, i.e. the last-grant pointer flips each RESPOND.
- Undefined: fixed priority, D always wins over I. The pointer register still exists but does not affect arbitration.

Test Plan:
- Reset then D_READ, D_ADDRESS=0x0000010, memory returns 0xA5..A5 one cycle after the strobe:
  - MEM_READ high cycles 1-2.
  - D_BUSYWAIT low only in cycle 3.
  - D_READDATA=0xA5..A5.
  - GRANT=10 in cycles 1-3.
- I_WRITE, I_ADDRESS=0x0000004, I_WRITEDATA=0x0123..CDEF:
  - MEM_WRITE high with MEM_ADDRESS=0x0000004 and the data held 2 cycles.
  - I_READDATA unchanged.
  - I_BUSYWAIT low cycle 3.
- I_READ and D_READ raised together, held across completions:
  - Without macro: D, D, D... granted (I starves).
  - With macro: D, I, D, I alternate, one IDLE cycle between grants.
- Memory stretches MEM_BUSYWAIT 5 cycles: ACCESS lasts 6 cycles, strobes stable, RESPOND follows the first low sample.
- D_READ=D_WRITE=1 for 8 cycles: no grant, GRANT=00, ERR pulses at cycles 0 and 4, D_BUSYWAIT=1; concurrent I_READ is still serviced.
- RESET_N pulled low in the second ACCESS cycle: MEM_READ, GRANT, ERR drop to 0 immediately; after release the FSM is IDLE and the next request completes normally.
